// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select codes and in-flight slot type for the forwarding controller
package fwd_pkg;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    // Slot register field is sized for the widest supported register file;
    // narrower addresses are zero-extended on entry.
    localparam int WD_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [WD_MAX-1:0] wd;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - compares one ID source operand against one in-flight slot
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic              id_valid,
    input  logic              uses,
    input  logic [REG_AW-1:0] src,
    input  slot_t             slot,
    output logic              hit
);

    assign hit = id_valid & uses & slot.valid & slot.wr_en & (slot.wd == WD_MAX'(src));

endmodule

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - forwarding select and load-use stall controller; optional FWD_STATS_EN counters
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_uses_ra,
    input  logic              id_uses_rb,
    input  logic              id_imm_b,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wd,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]       fwd_count,
    output logic [15:0]       stall_count
`endif
);

    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      wb_slot;
    logic       hit_a_ex;
    logic       hit_b_ex;
    logic       hit_a_mem;
    logic       hit_b_mem;
    logic       uses_rb_reg;
    logic       bubble;
    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;

    // An immediate B operand never reads rb, so rb cannot hazard.
    assign uses_rb_reg = id_uses_rb & ~id_imm_b;

    fwd_match #(.REG_AW(REG_AW)) u_match_a_ex (
        .id_valid (id_valid),
        .uses     (id_uses_ra),
        .src      (id_ra),
        .slot     (ex_slot),
        .hit      (hit_a_ex)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_b_ex (
        .id_valid (id_valid),
        .uses     (uses_rb_reg),
        .src      (id_rb),
        .slot     (ex_slot),
        .hit      (hit_b_ex)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_a_mem (
        .id_valid (id_valid),
        .uses     (id_uses_ra),
        .src      (id_ra),
        .slot     (mem_slot),
        .hit      (hit_a_mem)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_b_mem (
        .id_valid (id_valid),
        .uses     (uses_rb_reg),
        .src      (id_rb),
        .slot     (mem_slot),
        .hit      (hit_b_mem)
    );

    assign stall  = ~flush & ex_slot.is_load & (hit_a_ex | hit_b_ex);
    assign bubble = stall | flush | ~id_valid;

    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (!bubble) begin
            if (hit_a_ex && !ex_slot.is_load) begin
                sel_a_nxt = SEL_EXMEM;
            end else if (hit_a_mem) begin
                sel_a_nxt = SEL_MEMWB;
            end
            if (id_imm_b) begin
                sel_b_nxt = SEL_IMM;
            end else if (hit_b_ex && !ex_slot.is_load) begin
                sel_b_nxt = SEL_EXMEM;
            end else if (hit_b_mem) begin
                sel_b_nxt = SEL_MEMWB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
            wb_slot  <= SLOT_EMPTY;
            sel_a    <= SEL_RF;
            sel_b    <= SEL_RF;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (bubble) begin
                ex_slot <= SLOT_EMPTY;
            end else begin
                ex_slot.valid   <= 1'b1;
                ex_slot.wr_en   <= id_wr_en;
                ex_slot.wd      <= WD_MAX'(id_wd);
                ex_slot.is_load <= id_is_load;
            end
            sel_a <= sel_a_nxt;
            sel_b <= sel_b_nxt;
        end
    end

    // The WB producer is covered by the write-before-read register file;
    // its slot is tracked but never selects a forward.
    logic wb_slot_unused;
    assign wb_slot_unused = ^wb_slot;

`ifdef FWD_STATS_EN
    logic fwd_event;

    assign fwd_event = (sel_a_nxt == SEL_EXMEM) | (sel_a_nxt == SEL_MEMWB) |
                       (sel_b_nxt == SEL_EXMEM) | (sel_b_nxt == SEL_MEMWB);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (fwd_event && fwd_count != 16'hFFFF) begin
                fwd_count <= fwd_count + 16'd1;
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - directed and randomized checks of fwd_ctrl against an issue-history model
module tb_fwd_ctrl;

    localparam int REG_AW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_ra;
    logic [REG_AW-1:0] id_rb;
    logic              id_uses_ra;
    logic              id_uses_rb;
    logic              id_imm_b;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wd;
    logic              id_is_load;
    logic              flush;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              stall;
`ifdef FWD_STATS_EN
    logic [15:0]       fwd_count;
    logic [15:0]       stall_count;
`endif

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_AW(REG_AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .id_valid   (id_valid),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_uses_ra (id_uses_ra),
        .id_uses_rb (id_uses_rb),
        .id_imm_b   (id_imm_b),
        .id_wr_en   (id_wr_en),
        .id_wd      (id_wd),
        .id_is_load (id_is_load),
        .flush      (flush),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .stall      (stall)
`ifdef FWD_STATS_EN
        ,
        .fwd_count  (fwd_count),
        .stall_count(stall_count)
`endif
    );

    // Issue history: index 0 is the instruction now in EX, index 1 the one in MEM.
    typedef struct {
        bit v;
        bit wr;
        int wd;
        bit ld;
    } instr_t;

    instr_t hist[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     exp_fwd     = 0;
    int     exp_stalls  = 0;
    bit     last_stall  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t empty_instr();
        instr_t e;
        e.v = 0; e.wr = 0; e.wd = 0; e.ld = 0;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(empty_instr());
        hist.push_back(empty_instr());
        exp_fwd    = 0;
        exp_stalls = 0;
    endtask

    function automatic bit writes(instr_t p, int r);
        return p.v && p.wr && (p.wd == r);
    endfunction

    function automatic bit model_stall();
        if (!id_valid || flush) return 0;
        return hist[0].ld && ((id_uses_ra && writes(hist[0], int'(id_ra))) ||
                              (id_uses_rb && !id_imm_b && writes(hist[0], int'(id_rb))));
    endfunction

    function automatic logic [1:0] model_sel(int r, bit uses);
        if (!uses) return 2'b00;
        if (writes(hist[0], r)) return 2'b01;
        if (writes(hist[1], r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic setin(input bit v, input int ra, input int rb, input bit ua, input bit ub,
                         input bit imm, input bit wr, input int wd, input bit ld, input bit fl);
        id_valid   = v;
        id_ra      = REG_AW'(ra);
        id_rb      = REG_AW'(rb);
        id_uses_ra = ua;
        id_uses_rb = ub;
        id_imm_b   = imm;
        id_wr_en   = wr;
        id_wd      = REG_AW'(wd);
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic nop();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One pipeline cycle: inputs already driven; check stall mid-cycle, sel after the edge.
    task automatic cycle(input string tag);
        bit         es;
        bit         issue;
        logic [1:0] ea;
        logic [1:0] eb;
        instr_t     ni;
        @(negedge clk);
        es = model_stall();
        chk({tag, "_stall"}, 16'(stall), 16'(es));
        issue = id_valid && !flush && !es;
        ea = 2'b00;
        eb = 2'b00;
        ni = empty_instr();
        if (issue) begin
            ea = model_sel(int'(id_ra), id_uses_ra);
            eb = id_imm_b ? 2'b11 : model_sel(int'(id_rb), id_uses_rb);
            ni.v = 1; ni.wr = id_wr_en; ni.wd = int'(id_wd); ni.ld = id_is_load;
        end
        @(posedge clk);
        hist.push_front(ni);
        void'(hist.pop_back());
        if ((ea == 2'b01 || ea == 2'b10 || eb == 2'b01 || eb == 2'b10) && exp_fwd < 65535)
            exp_fwd++;
        if (es && exp_stalls < 65535)
            exp_stalls++;
        last_stall = es;
        #1;
        chk({tag, "_sel_a"}, 16'(sel_a), 16'(ea));
        chk({tag, "_sel_b"}, 16'(sel_b), 16'(eb));
`ifdef FWD_STATS_EN
        chk({tag, "_fwd_count"}, fwd_count, 16'(exp_fwd));
        chk({tag, "_stall_count"}, stall_count, 16'(exp_stalls));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        nop();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_a", 16'(sel_a), 16'h0);
        chk("rst_sel_b", 16'(sel_b), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        reset_n = 1'b1;

        // ADD R1; ADD reads R1 as A
        setin(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cycle("tp1_prod");
        setin(1, 1, 2, 1, 1, 0, 1, 0, 0, 0); cycle("tp1_cons");
        chk("tp1_sel_a_ex", 16'(sel_a), 16'h1);
        nop(); cycle("gap"); cycle("gap");

        // ADD R2; NOP; SUB reads R2 as B
        setin(1, 0, 0, 0, 0, 0, 1, 2, 0, 0); cycle("tp2_prod");
        nop(); cycle("tp2_nop");
        setin(1, 0, 2, 1, 1, 0, 1, 0, 0, 0); cycle("tp2_cons");
        chk("tp2_sel_b_mem", 16'(sel_b), 16'h2);
        nop(); cycle("gap"); cycle("gap");

        // LOAD R3; ADD reads R3 as A: one bubble then MEM forward
        setin(1, 0, 0, 0, 0, 0, 1, 3, 1, 0); cycle("tp3_load");
        setin(1, 3, 0, 1, 0, 0, 1, 1, 0, 0); cycle("tp3_stall");
        chk("tp3_bubble_sel_a", 16'(sel_a), 16'h0);
        chk("tp3_stall_seen", 16'(last_stall), 16'h1);
        cycle("tp3_retry");
        chk("tp3_sel_a_mem", 16'(sel_a), 16'h2);
        nop(); cycle("gap"); cycle("gap");

        // LOAD R3 with flush on the dependent cycle
        setin(1, 0, 0, 0, 0, 0, 1, 3, 1, 0); cycle("tp4_load");
        setin(1, 3, 0, 1, 0, 0, 1, 1, 0, 1); cycle("tp4_flush");
        chk("tp4_flush_sel_a", 16'(sel_a), 16'h0);
        nop(); cycle("gap"); cycle("gap");

        // Immediate B with rb matching a pending load
        setin(1, 0, 0, 0, 0, 0, 1, 1, 1, 0); cycle("tp5_load");
        setin(1, 2, 1, 1, 1, 1, 1, 0, 0, 0); cycle("tp5_imm");
        chk("tp5_sel_b_imm", 16'(sel_b), 16'h3);
        nop(); cycle("gap"); cycle("gap");

        // Randomized stream; a stalled instruction is held in ID like a real IF/ID.
        for (int i = 0; i < 400; i++) begin
            if (last_stall) begin
                flush = ($urandom_range(0, 9) == 0);
            end else begin
                setin($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0);
            end
            cycle("rnd");
        end

        // Asynchronous reset mid-stream, then a consumer of the pre-reset producer.
        setin(1, 0, 0, 0, 0, 0, 1, 1, 1, 0); cycle("rst_prod");
        setin(1, 1, 1, 1, 1, 0, 1, 2, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_sel_a", 16'(sel_a), 16'h0);
        chk("midrst_sel_b", 16'(sel_b), 16'h0);
        chk("midrst_stall", 16'(stall), 16'h0);
`ifdef FWD_STATS_EN
        chk("midrst_fwd_count", fwd_count, 16'h0);
        chk("midrst_stall_count", stall_count, 16'h0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        setin(1, 1, 1, 1, 1, 0, 1, 2, 0, 0); cycle("post_rst");
        chk("post_rst_sel_a", 16'(sel_a), 16'h0);
        setin(1, 2, 0, 1, 0, 0, 1, 0, 0, 0); cycle("post_rst_fwd");
        chk("post_rst_fwd_sel_a", 16'(sel_a), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
